// File: rtl/gecko_pkg.sv
// gecko_pkg: shared key-load constants and state encoding for the gecko decryptor
package gecko_pkg;
  localparam int KEY_LENGTH_DEF = 7;
  localparam int LOAD_CYCLES = 16;
  localparam logic [4:0] LOAD_LAST = 5'(LOAD_CYCLES - 1);
  typedef enum logic {KEYLOAD, STREAM} state_t;
endpackage

// File: rtl/gecko_keyseq.sv
// gecko_keyseq: key-load sequencer feeding key bytes to the generator, then switching to STREAM
module gecko_keyseq
  import gecko_pkg::*;
#(
  parameter int KEY_LENGTH = KEY_LENGTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [KEY_LENGTH*8-1:0] key_in,
  output logic                    g_clken,
  output logic [7:0]              g_key,
  output logic                    stream
);
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [7:0] key_b [32];
  // Bytes past the key length are zero padding for the remaining load cycles
  for (genvar g = 0; g < 32; g++) begin : g_kb
    if (g < KEY_LENGTH) begin : g_on
      assign key_b[g] = key_in[g*8 +: 8];
    end else begin : g_off
      assign key_b[g] = 8'h00;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= KEYLOAD;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == KEYLOAD ? cnt + 5'd1 : cnt;
    end
  always_comb begin
    state_nx = state == KEYLOAD && cnt == LOAD_LAST ? STREAM : state;
  end
  assign g_clken = rst_n;
  assign g_key = rst_n && state == KEYLOAD ? key_b[cnt] : 8'h00;
  assign stream = state == STREAM;
endmodule

// File: rtl/gecko_dec.sv
// gecko_dec: stream decryptor XORing ciphertext with generator keystream after a 16-cycle key load.
// Optional GECKO_DEC_BYPASS_EN adds a bypass input that forwards bytes without consuming keystream.
module gecko_dec
  import gecko_pkg::*;
#(
  parameter int KEY_LENGTH = KEY_LENGTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [KEY_LENGTH*8-1:0] key_in,
`ifdef GECKO_DEC_BYPASS_EN
  input  logic                    bypass,
`endif
  output logic                    g_clken,
  output logic [7:0]              g_key,
  input  logic                    g_ready,
  input  logic [7:0]              g_dout,
  output logic                    g_next,
  input  logic                    s_valid,
  input  logic [7:0]              s_data,
  output logic                    s_ready,
  output logic                    m_valid,
  output logic [7:0]              m_data,
  input  logic                    m_ready,
  output logic                    key_done
);
  logic stream, ks_valid, acc, byp;
  logic [7:0] ks_buf;
  gecko_keyseq #(.KEY_LENGTH(KEY_LENGTH)) u_keyseq (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_in  (key_in),
    .g_clken (g_clken),
    .g_key   (g_key),
    .stream  (stream)
  );
`ifdef GECKO_DEC_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif
  assign key_done = stream;
  assign g_next = rst_n & stream & g_ready & ~ks_valid;
  assign s_ready = rst_n & stream & (ks_valid | byp) & (~m_valid | m_ready);
  assign acc = s_valid & s_ready;
  always_ff @(posedge clk)
    if (!rst_n) begin
      ks_valid <= 1'b0;
      ks_buf <= 8'h00;
      m_valid <= 1'b0;
      m_data <= 8'h00;
    end else begin
      ks_valid <= g_next | (ks_valid & ~(acc & ~byp));
      ks_buf <= g_next ? g_dout : ks_buf;
      m_valid <= acc | (m_valid & ~m_ready);
      m_data <= acc ? (byp ? s_data : s_data ^ ks_buf) : m_data;
    end
endmodule

// File: tb/tb_gecko_dec.sv
// tb_gecko_dec: directed bench for gecko_dec with a stub generator and a transaction-level model
module tb_gecko_dec;
  localparam int KL = 7;
`ifdef GECKO_DEC_BYPASS_EN
  localparam bit HAS_BYP = 1'b1;
`else
  localparam bit HAS_BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, g_clken, g_ready, g_next, s_valid, s_ready, m_valid, m_ready, key_done, bypass;
  logic [KL*8-1:0] key_in;
  logic [7:0] g_key, g_dout, s_data, m_data, kx, gen_val;
  logic gen_force;
  int gtmr, gidx, npulse = 0;
  int n_tests = 0, n_fail = 0;
  bit armed = 1'b0;
  int ld = 0;
  bit have_ks = 1'b0, out_v = 1'b0;
  logic [7:0] ks = 8'h00, out_d = 8'h00;
  logic [7:0] key_tbl [16] = '{8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  always #5 clk = ~clk;
  gecko_dec #(.KEY_LENGTH(KL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
`ifdef GECKO_DEC_BYPASS_EN
    .bypass   (bypass),
`endif
    .g_clken  (g_clken),
    .g_key    (g_key),
    .g_ready  (g_ready),
    .g_dout   (g_dout),
    .g_next   (g_next),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .key_done (key_done)
  );
  function automatic logic [7:0] rol8(input logic [7:0] v, input int s);
    logic [15:0] t;
    t = {v, v} << (s % 8);
    return t[15:8];
  endfunction
  // Stub generator: keystream is the XOR of all key bytes rotated per byte, so a zero key yields zeros
  always_comb begin
    kx = 8'h00;
    for (int i = 0; i < KL; i++) kx = kx ^ key_in[i*8 +: 8];
  end
  assign g_dout = gen_force ? gen_val : rol8(kx, gidx);
  always @(posedge clk)
    if (!rst_n) begin
      g_ready <= 1'b1;
      gtmr <= 0;
      gidx <= 0;
    end else if (g_next) begin
      g_ready <= 1'b0;
      gtmr <= 8;
      gidx <= gidx + 1;
      npulse <= npulse + 1;
    end else if (gtmr > 0) begin
      gtmr <= gtmr - 1;
      if (gtmr == 1) g_ready <= 1'b1;
    end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  // Model: load progress counts cycles; one buffered keystream byte and one output byte as booleans
  task automatic model_step();
    bit strm, e_next, e_sr, byp, acc;
    logic [7:0] e_key;
    if (!armed) return;
    byp = HAS_BYP && bypass;
    strm = rst_n && ld >= 16;
    e_key = (rst_n && ld < 16 && ld < KL) ? key_in[ld*8 +: 8] : 8'h00;
    e_next = strm && g_ready && !have_ks;
    e_sr = strm && (byp || have_ks) && (!out_v || m_ready);
    chk("g_clken", 32'(g_clken), 32'(rst_n));
    chk("g_key", 32'(g_key), 32'(e_key));
    chk("key_done", 32'(key_done), 32'(ld >= 16));
    chk("g_next", 32'(g_next), 32'(e_next));
    chk("s_ready", 32'(s_ready), 32'(e_sr));
    chk("m_valid", 32'(m_valid), 32'(out_v));
    chk("m_data", 32'(m_data), 32'(out_d));
    if (!rst_n) begin
      ld = 0;
      have_ks = 1'b0;
      out_v = 1'b0;
      out_d = 8'h00;
      ks = 8'h00;
    end else begin
      acc = s_valid && e_sr;
      if (out_v && m_ready) out_v = 1'b0;
      if (acc) begin
        out_v = 1'b1;
        out_d = byp ? s_data : s_data ^ ks;
        if (!byp) have_ks = 1'b0;
      end
      if (e_next) begin
        have_ks = 1'b1;
        ks = g_dout;
      end
      if (ld < 16) ld++;
    end
  endtask
  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d);
    int n = 0;
    drive_edge();
    s_valid = 1'b1;
    s_data = d;
    @(negedge clk);
    while (!s_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n >= 60) begin
      n_fail++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
    end
    drive_edge();
    s_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!key_done && n < 40);
    chk("key_done_wait", 32'(key_done), 32'd1);
  endtask
  task automatic do_reset(input logic [KL*8-1:0] k);
    drive_edge();
    rst_n = 1'b0;
    key_in = k;
    drive_edge();
    rst_n = 1'b1;
  endtask
  initial begin
    int p;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    m_ready = 1'b0;
    bypass = 1'b0;
    key_in = 56'h0123456789ABCD;
    gen_force = 1'b1;
    gen_val = 8'hFF;
    fork
      forever @(negedge clk) model_step();
    join_none
    @(posedge clk);
    armed = 1'b1;
    drive_edge();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("load_key%0d", i), 32'(g_key), 32'(key_tbl[i]));
      if (i == 15) chk("load_not_done", 32'(key_done), 32'd0);
    end
    @(negedge clk);
    chk("load_done16", 32'(key_done), 32'd1);
    send(8'h0F);
    chk("stub_xor", 32'(m_data), 32'h00F0);
    chk("stub_one_pulse", 32'(npulse), 32'd1);
    drive_edge();
    s_valid = 1'b1;
    s_data = 8'h12;
    repeat (12) @(negedge clk);
    chk("bp_sready", 32'(s_ready), 32'd0);
    chk("bp_hold", 32'(m_data), 32'h00F0);
    chk("bp_mvalid", 32'(m_valid), 32'd1);
    drive_edge();
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(s_ready), 32'd1);
    drive_edge();
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    chk("bp_second", 32'(m_data), 32'h00ED);
    chk("bp_second_v", 32'(m_valid), 32'd1);
    do_reset(56'h0123456789ABCD);
    @(negedge clk);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_keydone", 32'(key_done), 32'd0);
    chk("rst_key0", 32'(g_key), 32'h00CD);
    @(negedge clk);
    chk("rst_key1", 32'(g_key), 32'h00AB);
    gen_force = 1'b0;
    do_reset('0);
    m_ready = 1'b1;
    wait_done();
    send(8'h5A);
    chk("zero_key_5a", 32'(m_data), 32'h005A);
    send(8'hA5);
    chk("zero_key_a5", 32'(m_data), 32'h00A5);
    gen_force = 1'b1;
    gen_val = 8'h3C;
    do_reset(56'h0123456789ABCD);
    wait_done();
    repeat (3) @(negedge clk);
    p = npulse;
`ifdef GECKO_DEC_BYPASS_EN
    drive_edge();
    bypass = 1'b1;
    send(8'h33);
    chk("byp_data", 32'(m_data), 32'h0033);
    chk("byp_no_pulse", 32'(npulse), 32'(p));
    drive_edge();
    bypass = 1'b0;
`endif
    send(8'h00);
    chk("buffered_ks", 32'(m_data), 32'h003C);
    chk("buffered_pulse", 32'(npulse), 32'(p));
    drive_edge();
    gen_force = 1'b0;
    for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)));
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
